// File: rtl/vram_port_sched.sv
`default_nettype none
// ============================================================================
// Module   : vram_port_sched
// Purpose  : Single-port VRAM scheduler that merges host byte accesses with a
//            background fill engine. The host always wins; the fill engine
//            uses every cycle the host does not.
// Options  : VRAM_FILL_ABORT_EN adds the fill_abort input.
// Revision : 1.0 - initial release
// ============================================================================
module vram_port_sched #(
  parameter int VRAM_DEPTH = 24576
) (
  input  logic        user_clk,
  input  logic        rst,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [14:0] host_addr,
  input  logic [7:0]  host_wdata,
  output logic        host_ack,
  output logic        host_rvalid,
  output logic [7:0]  host_rdata,
  input  logic        fill_start,
  input  logic [14:0] fill_addr,
  input  logic [14:0] fill_len,
  input  logic [7:0]  fill_value,
`ifdef VRAM_FILL_ABORT_EN
  input  logic        fill_abort,
`endif
  output logic        fill_busy,
  output logic        fill_done,
  output logic [14:0] vram_addr,
  output logic [7:0]  vram_wdata,
  output logic        vram_we,
  input  logic [7:0]  vram_rdata
);

  localparam logic [0:0]  IDLE        = 1'b0;
  localparam logic [0:0]  FILL        = 1'b1;
  localparam logic [14:0] c_last_addr = 15'(VRAM_DEPTH - 1);

  logic [0:0]  r_state;
  logic [14:0] r_fill_ptr;
  logic [14:0] r_fill_rem;
  logic [7:0]  r_fill_val;
  logic        r_host_ack;
  logic        r_host_rvalid;
  logic        r_fill_busy;
  logic        r_fill_done;
  logic [14:0] r_vram_addr;
  logic [7:0]  r_vram_wdata;
  logic        r_vram_we;

  logic        w_abort;
  logic        w_host_grant;
  logic        w_fill_go;
  logic        w_fill_last;
  logic        w_fill_accept;
  logic        w_fill_empty;
  logic [14:0] w_fill_next;

`ifdef VRAM_FILL_ABORT_EN
  assign w_abort = fill_abort & (r_state == FILL);
`else
  assign w_abort = 1'b0;
`endif

  // A request still high during its own ack cycle must not be granted twice,
  // which also leaves every other slot free for the fill engine.
  assign w_host_grant  = host_req & ~r_host_ack;
  assign w_fill_go     = (r_state == FILL) & ~w_host_grant & ~w_abort;
  assign w_fill_last   = w_fill_go & (r_fill_rem == 15'd1);
  assign w_fill_accept = (r_state == IDLE) & fill_start & (fill_len != 15'd0);
  assign w_fill_empty  = (r_state == IDLE) & fill_start & (fill_len == 15'd0);
  assign w_fill_next   = (r_fill_ptr == c_last_addr) ? 15'd0 : r_fill_ptr + 15'd1;

  always_ff @(posedge user_clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_fill_ptr <= 15'd0;
      r_fill_rem <= 15'd0;
      r_fill_val <= 8'd0;
    end else if (w_fill_accept) begin
      r_state    <= FILL;
      r_fill_ptr <= fill_addr;
      r_fill_rem <= fill_len;
      r_fill_val <= fill_value;
    end else if (w_abort || w_fill_last) begin
      r_state    <= IDLE;
    end else if (w_fill_go) begin
      r_fill_ptr <= w_fill_next;
      r_fill_rem <= r_fill_rem - 15'd1;
    end
  end

  always_ff @(posedge user_clk or posedge rst) begin
    if (rst) begin
      r_vram_addr  <= 15'd0;
      r_vram_wdata <= 8'd0;
      r_vram_we    <= 1'b0;
    end else if (w_host_grant) begin
      r_vram_addr  <= host_addr;
      r_vram_wdata <= host_wdata;
      r_vram_we    <= host_we;
    end else if (w_fill_go) begin
      r_vram_addr  <= r_fill_ptr;
      r_vram_wdata <= r_fill_val;
      r_vram_we    <= 1'b1;
    end else begin
      r_vram_we    <= 1'b0;
    end
  end

  // Busy covers the cycle showing the last write; done follows it, which is
  // the only cycle where busy is still high while the state is back in IDLE.
  always_ff @(posedge user_clk or posedge rst) begin
    if (rst) begin
      r_host_ack    <= 1'b0;
      r_host_rvalid <= 1'b0;
      r_fill_busy   <= 1'b0;
      r_fill_done   <= 1'b0;
    end else begin
      r_host_ack    <= w_host_grant;
      r_host_rvalid <= r_host_ack & ~r_vram_we;
      r_fill_busy   <= w_fill_accept | ((r_state == FILL) & ~w_abort);
      r_fill_done   <= w_fill_empty | w_abort | (r_fill_busy & (r_state == IDLE));
    end
  end

  assign host_ack    = r_host_ack;
  assign host_rvalid = r_host_rvalid;
  assign host_rdata  = vram_rdata;
  assign fill_busy   = r_fill_busy;
  assign fill_done   = r_fill_done;
  assign vram_addr   = r_vram_addr;
  assign vram_wdata  = r_vram_wdata;
  assign vram_we     = r_vram_we;

endmodule
`default_nettype wire
